// File: rtl/mult_m_seq_if.sv
// Handshake and operand/result bundle for the sequential matrix multiplier.
// The master side issues operands and start; the slave side returns status and the result.
interface mult_m_seq_if #(
    parameter int N  = 5,
    parameter int EW = 8
);
    logic                start;
    logic [N*N*EW-1:0]   lin;
    logic [N*N*EW-1:0]   col;
    logic                busy;
    logic                done;
    logic [N*N*EW-1:0]   n_out;
    logic                ovf;

    modport master (
        output start, lin, col,
        input  busy, done, n_out, ovf
    );

    modport slave (
        input  start, lin, col,
        output busy, done, n_out, ovf
    );
endinterface

// File: rtl/mult_m_seq.sv
// Sequential NxN signed matrix multiplier using one shared MAC per clock, with overflow reporting.
// Define MULT_M_SEQ_SAT_EN to saturate out-of-range result elements instead of wrapping them.
module mult_m_seq #(
    parameter int N  = 5,
    parameter int EW = 8
) (
    input  logic         clk,
    input  logic         rst,
    mult_m_seq_if.slave  bus
);
    localparam int AW = 2*EW + $clog2(N);
    localparam int IW = $clog2(N);
    localparam int MW = N*N*EW;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                stateQ, stateD;
    logic [MW-1:0]         linQ, linD;
    logic [MW-1:0]         colQ, colD;
    logic [MW-1:0]         nOutQ, nOutD;
    logic signed [AW-1:0]  accQ, accD;
    logic [IW-1:0]         iQ, iD;
    logic [IW-1:0]         jQ, jD;
    logic [IW-1:0]         kQ, kD;
    logic                  busyQ, busyD;
    logic                  doneQ, doneD;
    logic                  ovfQ, ovfD;

    logic [EW-1:0]         aElem;
    logic [EW-1:0]         bElem;
    logic signed [AW-1:0]  aExt;
    logic signed [AW-1:0]  bExt;
    logic signed [AW-1:0]  accNext;
    logic [AW-EW:0]        accTop;
    logic                  inRange;
    logic [EW-1:0]         elemVal;

    // Datapath: fetch A[i][k] and B[k][j], sign-extend to accumulator width and MAC.
    always_comb begin
        aElem   = linQ[(N*N-1-(int'(iQ)*N+int'(kQ)))*EW +: EW];
        bElem   = colQ[(N*N-1-(int'(kQ)*N+int'(jQ)))*EW +: EW];
        aExt    = {{(AW-EW){aElem[EW-1]}}, aElem};
        bExt    = {{(AW-EW){bElem[EW-1]}}, bElem};
        accNext = accQ + aExt * bExt;
        // The value fits in EW signed bits only if every bit above the EW-1 sign bit matches it.
        accTop  = accNext[AW-1:EW-1];
        inRange = (accTop == '0) || (accTop == '1);
`ifdef MULT_M_SEQ_SAT_EN
        if (inRange) begin
            elemVal = accNext[EW-1:0];
        end else if (accNext[AW-1]) begin
            elemVal = {1'b1, {(EW-1){1'b0}}};
        end else begin
            elemVal = {1'b0, {(EW-1){1'b1}}};
        end
`else
        elemVal = accNext[EW-1:0];
`endif
    end

    always_comb begin
        stateD = stateQ;
        linD   = linQ;
        colD   = colQ;
        nOutD  = nOutQ;
        accD   = accQ;
        iD     = iQ;
        jD     = jQ;
        kD     = kQ;
        busyD  = busyQ;
        doneD  = 1'b0;
        ovfD   = ovfQ;

        unique case (stateQ)
            IDLE: begin
                if (bus.start) begin
                    linD   = bus.lin;
                    colD   = bus.col;
                    accD   = '0;
                    iD     = '0;
                    jD     = '0;
                    kD     = '0;
                    ovfD   = 1'b0;
                    busyD  = 1'b1;
                    stateD = CALC;
                end
            end

            CALC: begin
                if (kQ != IW'(N-1)) begin
                    kD   = kQ + IW'(1);
                    accD = accNext;
                end else begin
                    nOutD[(N*N-1-(int'(iQ)*N+int'(jQ)))*EW +: EW] = elemVal;
                    accD = '0;
                    kD   = '0;
                    if (!inRange) begin
                        ovfD = 1'b1;
                    end
                    if (jQ != IW'(N-1)) begin
                        jD = jQ + IW'(1);
                    end else begin
                        jD = '0;
                        if (iQ != IW'(N-1)) begin
                            iD = iQ + IW'(1);
                        end else begin
                            iD     = '0;
                            busyD  = 1'b0;
                            doneD  = 1'b1;
                            stateD = DONE;
                        end
                    end
                end
            end

            DONE: begin
                stateD = IDLE;
            end

            default: begin
                stateD = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ <= IDLE;
            linQ   <= '0;
            colQ   <= '0;
            nOutQ  <= '0;
            accQ   <= '0;
            iQ     <= '0;
            jQ     <= '0;
            kQ     <= '0;
            busyQ  <= 1'b0;
            doneQ  <= 1'b0;
            ovfQ   <= 1'b0;
        end else begin
            stateQ <= stateD;
            linQ   <= linD;
            colQ   <= colD;
            nOutQ  <= nOutD;
            accQ   <= accD;
            iQ     <= iD;
            jQ     <= jD;
            kQ     <= kD;
            busyQ  <= busyD;
            doneQ  <= doneD;
            ovfQ   <= ovfD;
        end
    end

    assign bus.busy  = busyQ;
    assign bus.done  = doneQ;
    assign bus.n_out = nOutQ;
    assign bus.ovf   = ovfQ;
endmodule

// File: tb/tb_mult_m_seq.sv
// Bench for mult_m_seq: an N=2 and an N=5 instance checked against a plain-arithmetic matrix model.
// Expected saturated/wrapped results follow MULT_M_SEQ_SAT_EN the same way the design does.
module tb_mult_m_seq;
    localparam int EW = 8;

    typedef logic [199:0] mat_t;

    typedef struct {
        int    n;
        mat_t  lin;
        mat_t  col;
        mat_t  expOut;
        logic  expOvf;
        string tag;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    mat_t last2 = '0;
    mat_t last5 = '0;

    always #5 clk = ~clk;

    mult_m_seq_if #(.N(2), .EW(EW)) if2 ();
    mult_m_seq_if #(.N(5), .EW(EW)) if5 ();

    mult_m_seq #(.N(2), .EW(EW)) dut2 (.clk(clk), .rst(rst), .bus(if2));
    mult_m_seq #(.N(5), .EW(EW)) dut5 (.clk(clk), .rst(rst), .bus(if5));

    function automatic int getEl(mat_t m, int n, int k);
        logic [EW-1:0] e;
        e = m[(n*n-1-k)*EW +: EW];
        return int'($signed(e));
    endfunction

    function automatic mat_t setEl(mat_t m, int n, int k, int v);
        mat_t r;
        r = m;
        r[(n*n-1-k)*EW +: EW] = v[EW-1:0];
        return r;
    endfunction

    // Reference: textbook triple loop with integer sums, then range rule on each element.
    task automatic refMul(input int n, input mat_t a, input mat_t b, output mat_t r, output logic ov);
        int s;
        int v;
        r  = '0;
        ov = 1'b0;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                s = 0;
                for (int k = 0; k < n; k++) begin
                    s += getEl(a, n, i*n+k) * getEl(b, n, k*n+j);
                end
                v = s;
                if (s > 127 || s < -128) begin
                    ov = 1'b1;
`ifdef MULT_M_SEQ_SAT_EN
                    v = (s > 127) ? 127 : -128;
`endif
                end
                r = setEl(r, n, i*n+j, v);
            end
        end
    endtask

    function automatic mat_t rndMat();
        mat_t m;
        m = '0;
        for (int b = 0; b < 25; b++) begin
            m[b*8 +: 8] = 8'($urandom);
        end
        return m;
    endfunction

    function automatic mat_t getOut(int n);
        mat_t r;
        r = '0;
        if (n == 2) r[31:0] = if2.n_out;
        else        r[199:0] = if5.n_out;
        return r;
    endfunction

    function automatic logic getBusy(int n);
        return (n == 2) ? if2.busy : if5.busy;
    endfunction

    function automatic logic getDone(int n);
        return (n == 2) ? if2.done : if5.done;
    endfunction

    function automatic logic getOvf(int n);
        return (n == 2) ? if2.ovf : if5.ovf;
    endfunction

    task automatic driveIn(input int n, input logic st, input mat_t a, input mat_t b);
        if (n == 2) begin
            if2.start = st;
            if2.lin   = a[31:0];
            if2.col   = b[31:0];
        end else begin
            if5.start = st;
            if5.lin   = a;
            if5.col   = b;
        end
    endtask

    task automatic checkOutput(input string name, input mat_t act, input mat_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Present operands with start for one sampling edge, then scramble the operand inputs.
    task automatic applyStimulus(input int n, input mat_t a, input mat_t b);
        @(negedge clk);
        driveIn(n, 1'b1, a, b);
        @(posedge clk);
        #1;
        driveIn(n, 1'b0, rndMat(), rndMat());
    endtask

    task automatic runOp(input int n, input mat_t a, input mat_t b, input mat_t exp, input logic eo,
                         input int pulseAt, input int resetAt, input bit startInDone, input string tag);
        int cyc;
        int busyCnt;
        bit seen;
        applyStimulus(n, a, b);
        checkOutput({tag, " hold"}, getOut(n), (n == 2) ? last2 : last5);
        busyCnt = getBusy(n) ? 1 : 0;
        cyc = 0;
        seen = 0;
        while (!seen && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            driveIn(n, 1'b0, rndMat(), rndMat());
            if (cyc == resetAt) begin
                #3;
                rst = 1'b0;
                #1;
                checkInt({tag, " rst busy"}, int'(getBusy(n)), 0);
                checkInt({tag, " rst done"}, int'(getDone(n)), 0);
                checkInt({tag, " rst ovf"}, int'(getOvf(n)), 0);
                checkOutput({tag, " rst out"}, getOut(n), '0);
                last2 = '0;
                last5 = '0;
                @(negedge clk);
                @(negedge clk);
                rst = 1'b1;
                @(posedge clk);
                #1;
                checkInt({tag, " rst nodone"}, int'(getDone(n)), 0);
                return;
            end
            if (getDone(n)) seen = 1;
            else if (getBusy(n)) busyCnt++;
            if (cyc == pulseAt) driveIn(n, 1'b1, rndMat(), rndMat());
        end
        checkInt({tag, " latency"}, cyc, n*n*n);
        checkInt({tag, " busycnt"}, busyCnt, n*n*n);
        checkOutput({tag, " result"}, getOut(n), exp);
        checkInt({tag, " ovf"}, int'(getOvf(n)), int'(eo));
        if (n == 2) last2 = exp;
        else        last5 = exp;
        if (startInDone) driveIn(n, 1'b1, rndMat(), rndMat());
        @(posedge clk);
        #1;
        driveIn(n, 1'b0, rndMat(), rndMat());
        checkInt({tag, " donepulse"}, int'(getDone(n)), 0);
        if (startInDone) begin
            @(posedge clk);
            #1;
            checkInt({tag, " doneign busy"}, int'(getBusy(n)), 0);
        end
        checkOutput({tag, " keep"}, getOut(n), exp);
        checkInt({tag, " ovf keep"}, int'(getOvf(n)), int'(eo));
    endtask

    initial begin
        vec_t tbl[5];
        mat_t a, b, e, id5;
        logic eo;
        int   satPos;

        driveIn(2, 1'b0, '0, '0);
        driveIn(5, 1'b0, '0, '0);

`ifdef MULT_M_SEQ_SAT_EN
        satPos = 127;
`else
        satPos = 5;
`endif
        id5 = '0;
        for (int i = 0; i < 5; i++) id5 = setEl(id5, 5, i*5+i, 1);

        tbl[0].n = 2; tbl[0].tag = "t2x2"; tbl[0].expOvf = 1'b0;
        tbl[0].lin = '0; tbl[0].col = '0; tbl[0].expOut = '0;
        for (int k = 0; k < 4; k++) begin
            tbl[0].lin = setEl(tbl[0].lin, 2, k, k+1);
            tbl[0].col = setEl(tbl[0].col, 2, k, k+5);
        end
        tbl[0].expOut = setEl(tbl[0].expOut, 2, 0, 19);
        tbl[0].expOut = setEl(tbl[0].expOut, 2, 1, 22);
        tbl[0].expOut = setEl(tbl[0].expOut, 2, 2, 43);
        tbl[0].expOut = setEl(tbl[0].expOut, 2, 3, 50);

        tbl[1].n = 5; tbl[1].tag = "tident"; tbl[1].expOvf = 1'b0;
        tbl[2].n = 5; tbl[2].tag = "tpos"; tbl[2].expOvf = 1'b1;
        tbl[3].n = 5; tbl[3].tag = "tneg"; tbl[3].expOvf = 1'b1;
        tbl[4].n = 5; tbl[4].tag = "tii"; tbl[4].expOvf = 1'b0;
        tbl[1].lin = id5; tbl[1].col = '0; tbl[1].expOut = '0;
        tbl[2].lin = '0; tbl[2].col = '0; tbl[2].expOut = '0;
        tbl[3].lin = '0; tbl[3].col = '0; tbl[3].expOut = '0;
        tbl[4].lin = id5; tbl[4].col = id5; tbl[4].expOut = id5;
        for (int k = 0; k < 25; k++) begin
            tbl[1].col    = setEl(tbl[1].col, 5, k, k+1);
            tbl[1].expOut = setEl(tbl[1].expOut, 5, k, k+1);
            tbl[2].lin    = setEl(tbl[2].lin, 5, k, 127);
            tbl[2].col    = setEl(tbl[2].col, 5, k, 127);
            tbl[2].expOut = setEl(tbl[2].expOut, 5, k, satPos);
            tbl[3].lin    = setEl(tbl[3].lin, 5, k, -128);
            tbl[3].col    = setEl(tbl[3].col, 5, k, 1);
            tbl[3].expOut = setEl(tbl[3].expOut, 5, k, -128);
        end

        #12;
        checkInt("reset busy2", int'(getBusy(2)), 0);
        checkInt("reset done2", int'(getDone(2)), 0);
        checkInt("reset ovf5", int'(getOvf(5)), 0);
        checkOutput("reset out5", getOut(5), '0);
        @(negedge clk);
        rst = 1'b1;

        for (int t = 0; t < 5; t++) begin
            runOp(tbl[t].n, tbl[t].lin, tbl[t].col, tbl[t].expOut, tbl[t].expOvf, -1, -1, 1'b0, tbl[t].tag);
        end

        // Restart attempt mid-operation must be ignored.
        a = rndMat(); b = rndMat();
        refMul(5, a, b, e, eo);
        runOp(5, a, b, e, eo, 40, -1, 1'b0, "midstart");

        // Start presented while done is high must be ignored.
        a = rndMat(); b = rndMat();
        refMul(2, a, b, e, eo);
        runOp(2, a, b, e, eo, -1, -1, 1'b1, "donestart");

        // Asynchronous reset mid-operation, then a clean operation.
        a = rndMat(); b = rndMat();
        refMul(5, a, b, e, eo);
        runOp(5, a, b, e, eo, -1, 60, 1'b0, "midreset");
        a = rndMat(); b = rndMat();
        refMul(5, a, b, e, eo);
        runOp(5, a, b, e, eo, -1, -1, 1'b0, "postreset");

        for (int r = 0; r < 4; r++) begin
            a = rndMat(); b = rndMat();
            refMul(2, a, b, e, eo);
            runOp(2, a, b, e, eo, -1, -1, 1'b0, "rnd2");
            a = rndMat(); b = rndMat();
            refMul(5, a, b, e, eo);
            runOp(5, a, b, e, eo, -1, -1, 1'b0, "rnd5");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mult_m_seq.md
Name: mult_m_seq

Overview:
- Sequential, parametrised successor of the combinational 5x5 matrix multiplier: computes n_out = lin x col for two NxN signed matrices.
- Uses one shared multiply-accumulate unit, one MAC per clock.
- Latches operands on a start handshake, signals busy/done and reports overflow.
- Sits behind the coprocessor's instruction decoder as the matrix-multiply execution unit; sized for N up to 5, EW up to 16.

Parameters:
- N, 5, matrix dimension (rows = cols), 2..5
- EW, 8, signed element width in bits
- Derived (localparam, not overridable): AW = 2*EW + clog2(N), the accumulator width

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  request a multiply; sampled only in IDLE
- lin  input  N*N*EW  left matrix, row-major; element (0,0) in MSBs; element k=i*N+j at bits [(N*N-1-k)*EW +: EW]
- col  input  N*N*EW  right matrix, same packing
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse; n_out and ovf are valid
- n_out  output  N*N*EW  result matrix, same packing; held until next start
- ovf  output  1  high if any result element exceeded the signed EW range in the last operation

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy=0, done=0, ovf=0, n_out=0; internal operand registers, accumulator and indices i/j/k = 0.
- FSM states: IDLE, CALC, DONE.
- IDLE: on edge with start=1, latch lin/col into internal registers, clear accumulator, i=j=k=0, ovf=0, busy=1, go to CALC. n_out keeps its previous value. lin/col may change freely after the sampling edge.
- CALC: each edge computes acc_next = acc + A[i][k]*B[k][j], all signed at AW bits (sign-extended, no intermediate overflow possible).
  - If k<N-1: k++.
  - If k=N-1: write element (i,j) of n_out from acc_next, clear acc, k=0, advance j then i in row-major order.
  - After writing element (N-1,N-1): busy=0, done=1, go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE (done=0). start during DONE is ignored.
- Latency: done is high in the cycle beginning N^3 edges after the start-sampling edge (125 for N=5, 8 for N=2). busy is high for N^3 cycles.
- Result range rule: if acc_next > 2^(EW-1)-1 or < -2^(EW-1), set ovf=1. ovf is sticky for the operation and holds after done until the next accepted start.
- Default element value is the low EW bits of acc_next (two's-complement wrap).
- start while busy or in DONE: ignored, with no effect on the operation in progress.
- Reset mid-operation: abort immediately with all reset values; no done pulse.
- No output is driven from combinational paths of inputs; all outputs are registered.

Optional Feature:
- Macro: MULT_M_SEQ_SAT_EN
- Defined: out-of-range elements saturate to 2^(EW-1)-1 (positive) or -2^(EW-1) (negative); ovf still set.
- Undefined: elements wrap to the low EW bits; ovf set identically.
- Latency and handshake are identical in both builds.

Test Plan:
- N=2, EW=8: lin=[1,2,3,4], col=[5,6,7,8], start one cycle -> done 8 cycles after start edge; n_out=[19,22,43,50]; ovf=0; busy high for 8 cycles.
- N=5: lin=identity, col=[1..25] -> n_out=[1..25], ovf=0, done at cycle 125; change lin/col to random after the start edge -> result unchanged.
- N=5: all lin=127, all col=127 (each sum 80645) -> ovf=1; n_out all 0x05 without MULT_M_SEQ_SAT_EN; all 0x7F with it.
- N=5: all lin=-128, all col=1 (each sum -640) -> ovf=1; n_out all 0x80 in both builds. Then a start with identity x identity -> ovf clears to 0, n_out=identity.
- Pulse start again at cycle 40 of an operation -> ignored; exactly one done, at cycle 125, with the correct result.
- Assert rst=0 at cycle 60 asynchronously (between edges) -> busy/done/ovf/n_out go to 0 immediately; after release, a new start completes normally.
